// File: rtl/powlib_busrrarb_pkg.sv
// -----------------------------------------------------------------------------
// powlib_busrrarb_pkg
// Shared elaboration-time helpers for the powlib arbiters:
//   clog2     - ceiling log2, with clog2(1) == 0
//   idx_width - width of an index into n items (never less than 1 bit)
// No ports; imported by the arbiter and its selector.
// -----------------------------------------------------------------------------
package powlib_busrrarb_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/powlib_flipflop.sv
// -----------------------------------------------------------------------------
// powlib_flipflop
// Generic enabled register with synchronous active-low reset.
// Ports:
//   clk   in   clock
//   i_rst in   synchronous reset, active low (tie to 1 for a reset-less register)
//   i_en  in   load enable
//   i_d   in   W-bit next value
//   o_q   out  W-bit registered value
// -----------------------------------------------------------------------------
module powlib_flipflop #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // NOTE: sequential state is always written with <= so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!i_rst) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/powlib_rrsel.sv
// -----------------------------------------------------------------------------
// powlib_rrsel
// Combinational rotating-priority selector: picks the first set request
// scanning i_ptr, i_ptr+1, ... wrapping modulo N.
// Ports:
//   i_req in   N-bit request vector
//   i_ptr in   IW-bit start index (must be < N)
//   o_gnt out  one-hot winner, zero when no request
//   o_idx out  index of the winner (0 when none)
//   o_any out  at least one request present
// -----------------------------------------------------------------------------
module powlib_rrsel #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_j;

  // NOTE: every output gets a default before the loop; a path that leaves a
  // combinational output unassigned would infer a latch.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/powlib_busrrarb.sv
// -----------------------------------------------------------------------------
// powlib_busrrarb
// Round-robin, burst-aware arbiter merging B_WRS valid/ready bus writers onto
// one registered bus reader. A writer keeps the bus for up to BURST
// consecutive beats while it stays valid, then priority rotates past it.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active low
//   wrdatas  in   writer datas, writer i at [i*B_DW +: B_DW]
//   wraddrs  in   writer addresses, writer i at [i*B_AW +: B_AW]
//   wrvlds   in   writer valids
//   wrrdys   out  writer readies, at most one set per cycle
//   rddata   out  registered read data
//   rdaddr   out  registered read address
//   rdvld    out  registered read valid
//   rdrdy    in   read ready
//   gnt      out  combinational one-hot winner, zero if none
//   lock     out  registered: a burst is in progress
// -----------------------------------------------------------------------------
module powlib_busrrarb
  import powlib_busrrarb_pkg::*;
#(
  parameter int    B_WRS = 4,
  parameter int    B_AW  = 2,
  parameter int    B_DW  = 4,
  parameter int    BURST = 1,
  parameter string ID    = "BUSRRARB",
  parameter int    EDBG  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [B_WRS*B_DW-1:0] wrdatas,
  input  logic [B_WRS*B_AW-1:0] wraddrs,
  input  logic [B_WRS-1:0]      wrvlds,
  output logic [B_WRS-1:0]      wrrdys,
  output logic [B_DW-1:0]       rddata,
  output logic [B_AW-1:0]       rdaddr,
  output logic                  rdvld,
  input  logic                  rdrdy,
  output logic [B_WRS-1:0]      gnt,
  output logic                  lock
);

  localparam int            IW      = idx_width(B_WRS);
  localparam int            CW      = clog2(BURST) + 1;
  localparam logic [IW-1:0] LAST    = IW'(B_WRS - 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  // Arbitration state
  logic          r_lock;
  logic [IW-1:0] r_own;
  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;

  logic             w_own_vld;
  logic             w_hold;
  logic             w_rel;
  logic [IW-1:0]    w_own_nxt;
  logic [IW-1:0]    w_scan_ptr;
  logic [B_WRS-1:0] w_sel_gnt;
  logic [IW-1:0]    w_sel_idx;
  logic             w_sel_any;
  logic [B_WRS-1:0] w_win;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic             w_load;
  logic             w_xfer;
  logic [CW-1:0]    w_beats;
  logic             w_rdvld_nxt;
  logic [B_DW-1:0]  w_win_data;
  logic [B_AW-1:0]  w_win_addr;

  assign w_own_vld = wrvlds[r_own];
  assign w_hold    = r_lock && w_own_vld;
  // The burst owner went idle: give up the bus and scan from the writer after it
  // in this same cycle, so no bubble is inserted.
  assign w_rel      = r_lock && !w_own_vld;
  assign w_own_nxt  = (r_own == LAST) ? '0 : r_own + IW'(1);
  assign w_scan_ptr = w_rel ? w_own_nxt : r_ptr;

  powlib_rrsel #(
    .N  (B_WRS),
    .IW (IW)
  ) u_rrsel (
    .i_req (wrvlds),
    .i_ptr (w_scan_ptr),
    .o_gnt (w_sel_gnt),
    .o_idx (w_sel_idx),
    .o_any (w_sel_any)
  );

  // A locked owner that is still valid overrides the rotating scan.
  always_comb begin
    w_win = w_sel_gnt;
    w_idx = w_sel_idx;
    if (w_hold) begin
      w_win        = '0;
      w_win[r_own] = 1'b1;
      w_idx        = r_own;
    end
    if (!rst) begin
      w_win = '0;
    end
  end

  assign w_load    = !rdvld || rdrdy;
  assign gnt       = w_win;
  assign wrrdys    = w_win & {B_WRS{w_load}};
  assign w_xfer    = |(wrrdys & wrvlds);
  assign w_idx_nxt = (w_idx == LAST) ? '0 : w_idx + IW'(1);

  // Beat number the winner reaches with this transfer.
  assign w_beats = (r_lock && (r_own == w_idx)) ? r_cnt + CW'(1) : CW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lock <= 1'b0;
      r_own  <= '0;
      r_cnt  <= '0;
      r_ptr  <= '0;
    end else if (w_xfer) begin
      if (w_beats < BURST_C) begin
        r_lock <= 1'b1;
        r_own  <= w_idx;
        r_cnt  <= w_beats;
        if (w_rel) begin
          r_ptr <= w_own_nxt;
        end
      end else begin
        r_lock <= 1'b0;
        r_cnt  <= '0;
        r_ptr  <= w_idx_nxt;
      end
    end else if (w_rel && w_load) begin
      r_lock <= 1'b0;
      r_cnt  <= '0;
      r_ptr  <= w_own_nxt;
    end
  end

  assign lock = r_lock;

  // One-entry output register
  assign w_win_data  = wrdatas[w_idx*B_DW +: B_DW];
  assign w_win_addr  = wraddrs[w_idx*B_AW +: B_AW];
  assign w_rdvld_nxt = w_xfer ? 1'b1 : (rdrdy ? 1'b0 : rdvld);

  powlib_flipflop #(
    .W       (1),
    .RST_VAL (1'b0)
  ) u_rdvld_ff (
    .clk   (clk),
    .i_rst (rst),
    .i_en  (1'b1),
    .i_d   (w_rdvld_nxt),
    .o_q   (rdvld)
  );

  // NOTE: the payload register is deliberately reset-less; rdvld qualifies it,
  // so resetting the data path would only cost reset routing.
  powlib_flipflop #(
    .W (B_DW + B_AW)
  ) u_rdpay_ff (
    .clk   (clk),
    .i_rst (1'b1),
    .i_en  (w_xfer),
    .i_d   ({w_win_data, w_win_addr}),
    .o_q   ({rddata, rdaddr})
  );

  // Simulation-only grant sanity check, enabled with EDBG.
  if (EDBG != 0) begin : g_dbg
    always_ff @(posedge clk) begin
      if (rst) begin
        assert ($onehot0(wrrdys))
          else $error("%s: more than one writer granted", ID);
      end
    end
  end

endmodule

// File: tb/tb_powlib_busrrarb.sv
// -----------------------------------------------------------------------------
// tb_powlib_busrrarb
// Directed bench for powlib_busrrarb. Three instances share clock, reset and
// writer payloads: u1 (BURST=1), u3 (BURST=3), u4 (BURST=4). Each is exercised
// in turn while the others see no requests.
// Writer i drives address i and data 0xA+i.
// -----------------------------------------------------------------------------
module tb_powlib_busrrarb;

  logic        clk;
  logic        rst;
  logic [15:0] wrdatas;
  logic [7:0]  wraddrs;

  logic [3:0] vld1, vld3, vld4;
  logic       rdy1, rdy3, rdy4;
  logic [3:0] rrdys1, rrdys3, rrdys4;
  logic [3:0] gnt1, gnt3, gnt4;
  logic [3:0] rddata1, rddata3, rddata4;
  logic [1:0] rdaddr1, rdaddr3, rdaddr4;
  logic       rdvld1, rdvld3, rdvld4;
  logic       lock1, lock3, lock4;

  int n_checks = 0;
  int n_errors = 0;

  powlib_busrrarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .BURST(1)) u1 (
    .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs),
    .wrvlds(vld1), .wrrdys(rrdys1), .rddata(rddata1), .rdaddr(rdaddr1),
    .rdvld(rdvld1), .rdrdy(rdy1), .gnt(gnt1), .lock(lock1)
  );

  powlib_busrrarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .BURST(3)) u3 (
    .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs),
    .wrvlds(vld3), .wrrdys(rrdys3), .rddata(rddata3), .rdaddr(rdaddr3),
    .rdvld(rdvld3), .rdrdy(rdy3), .gnt(gnt3), .lock(lock3)
  );

  powlib_busrrarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .BURST(4)) u4 (
    .clk(clk), .rst(rst), .wrdatas(wrdatas), .wraddrs(wraddrs),
    .wrvlds(vld4), .wrrdys(rrdys4), .rddata(rddata4), .rdaddr(rdaddr4),
    .rdvld(rdvld4), .rdrdy(rdy4), .gnt(gnt4), .lock(lock4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         burst_w[9]    = '{0, 0, 0, 2, 2, 2, 0, 0, 0};
  logic       burst_lock[9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};

  initial begin
    rst     = 1'b0;
    wrdatas = {4'hD, 4'hC, 4'hB, 4'hA};
    wraddrs = {2'd3, 2'd2, 2'd1, 2'd0};
    vld1 = '0; vld3 = '0; vld4 = '0;
    rdy1 = 1'b1; rdy3 = 1'b1; rdy4 = 1'b1;

    // Reset with all writers requesting: nothing granted, nothing out.
    vld1 = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_wrrdys", rrdys1, 4'b0000);
      check("rst_gnt",    gnt1,   4'b0000);
      check("rst_rdvld",  rdvld1, 1'b0);
      check("rst_lock",   lock1,  1'b0);
    end
    rst = 1'b1;
    #1;

    // Fairness, BURST=1: 0,1,2,3,0,1,2,3 with no bubbles.
    for (int k = 0; k < 8; k++) begin
      check("fair_wrrdys", rrdys1, 32'(4'b0001 << (k % 4)));
      step();
      check("fair_rdvld", rdvld1,  1'b1);
      check("fair_addr",  rdaddr1, 32'(k % 4));
      check("fair_data",  rddata1, 32'(4'hA + (k % 4)));
      check("fair_lock",  lock1,   1'b0);
    end
    vld1 = '0;
    step();
    check("fair_drain", rdvld1, 1'b0);

    // Backpressure: beat from writer 0 held 5 cycles, then resume 1,2.
    vld1 = 4'b1111;
    #1;
    check("bp_first_rdy", rrdys1, 4'b0001);
    step();
    check("bp_addr0", rdaddr1, 2'd0);
    rdy1 = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp_wrrdys", rrdys1,   4'b0000);
      check("bp_rdvld",  rdvld1,   1'b1);
      check("bp_data",   rddata1,  4'hA);
      check("bp_addr",   rdaddr1,  2'd0);
      check("bp_ptr",    u1.r_ptr, 2'd1);
      step();
    end
    rdy1 = 1'b1;
    #1;
    check("bp_resume_rdy", rrdys1, 4'b0010);
    step();
    check("bp_resume_a1", rdaddr1, 2'd1);
    check("bp_resume_rdy2", rrdys1, 4'b0100);
    step();
    check("bp_resume_a2", rdaddr1, 2'd2);
    vld1 = '0;
    step();
    check("bp_drain", rdvld1, 1'b0);

    // Bursts, BURST=3: writers 0 and 2 -> 0,0,0,2,2,2,0,0,0.
    vld3 = 4'b0101;
    #1;
    for (int k = 0; k < 9; k++) begin
      check("burst_gnt", gnt3, 32'(4'b0001 << burst_w[k]));
      step();
      check("burst_rdvld", rdvld3,  1'b1);
      check("burst_addr",  rdaddr3, 32'(burst_w[k]));
      check("burst_lock",  lock3,   burst_lock[k]);
    end
    vld3 = '0;
    step();
    check("burst_drain", rdvld3, 1'b0);

    // Early release, BURST=4: writer 1 for 2 beats, then writer 3 with no gap.
    vld4 = 4'b1010;
    #1;
    check("rel_gnt1", gnt4, 4'b0010);
    step();
    check("rel_beat1", rdaddr4, 2'd1);
    check("rel_lock1", lock4,   1'b1);
    step();
    check("rel_beat2", rdaddr4, 2'd1);
    vld4 = 4'b1000;
    #1;
    check("rel_nobubble", rrdys4, 4'b1000);
    step();
    check("rel_beat3_vld", rdvld4,   1'b1);
    check("rel_beat3",     rdaddr4,  2'd3);
    check("rel_ptr",       u4.r_ptr, 2'd2);
    check("rel_lock3",     lock4,    1'b1);
    vld4 = '0;
    step();
    check("rel_idle_vld",  rdvld4, 1'b0);
    check("rel_idle_lock", lock4,  1'b0);

    // Reset in the middle of a writer-2 burst.
    vld4 = 4'b0100;
    step();
    check("mid_beat1", rdaddr4, 2'd2);
    step();
    check("mid_beat2", rdaddr4, 2'd2);
    check("mid_lock",  lock4,   1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_rdy", rrdys4, 4'b0000);
    check("mid_rst_gnt", gnt4,   4'b0000);
    step();
    check("mid_rst_vld",  rdvld4, 1'b0);
    check("mid_rst_lock", lock4,  1'b0);
    rst  = 1'b1;
    vld4 = 4'b0101;
    #1;
    check("mid_after_gnt", gnt4,   4'b0001);
    check("mid_after_rdy", rrdys4, 4'b0001);
    step();
    check("mid_after_vld",  rdvld4,  1'b1);
    check("mid_after_addr", rdaddr4, 2'd0);
    check("mid_after_data", rddata4, 4'hA);
    vld4 = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
